// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// States, owner encoding and default geometry/latency constants.
package dmem_arb_pkg;

    localparam int DEF_AW      = 10;
    localparam int DEF_MEM_LAT = 1;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the CPU and loader requesters.
// Build option: DMEM_ARB_RR_EN selects round-robin ties; otherwise the CPU always wins.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_ldr
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        grant_valid = cpu_req | ldr_req;
        grant_ldr   = ldr_req;
        // On a tie the requester that was not served last goes next.
        if (cpu_req && ldr_req) begin
            grant_ldr = (last_owner == OWN_CPU);
        end
    end
`else
    logic unused_last_owner;

    assign unused_last_owner = last_owner;

    always_comb begin
        grant_valid = cpu_req | ldr_req;
        grant_ldr   = ldr_req & ~cpu_req;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: serialises MEM-stage and loader accesses onto one fixed-latency port.
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking (see dmem_arb_pick).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [15:0]   cpu_addr,
    input  logic [15:0]   cpu_wdata,
    output logic [15:0]   cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_stall,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [15:0]   ldr_addr,
    input  logic [15:0]   ldr_wdata,
    output logic [15:0]   ldr_rdata,
    output logic          ldr_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

    arb_state_t       state_reg;
    arb_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    owner_t           owner_reg;
    owner_t           last_owner_reg;
    logic             we_reg;
    logic [AW-1:0]    addr_reg;
    logic [15:0]      wdata_reg;
    logic [15:0]      cpu_rdata_reg;
    logic [15:0]      ldr_rdata_reg;
    logic             cpu_done_reg;
    logic             ldr_done_reg;
    logic             grant_valid;
    logic             grant_ldr;
    logic             unused_addr_bits;

    // Byte addresses: bit 0 selects a byte lane and the bits above the word range wrap.
    assign unused_addr_bits = ^{cpu_addr[15:AW+1], cpu_addr[0], ldr_addr[15:AW+1], ldr_addr[0]};

    dmem_arb_pick u_pick (
        .cpu_req     (cpu_req),
        .ldr_req     (ldr_req),
        .last_owner  (last_owner_reg),
        .grant_valid (grant_valid),
        .grant_ldr   (grant_ldr)
    );

    // State advances on the falling edge so it lines up with the pipeline update edge.
    always_ff @(negedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            owner_reg      <= OWN_CPU;
            last_owner_reg <= OWN_LDR;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cpu_rdata_reg  <= '0;
            ldr_rdata_reg  <= '0;
            cpu_done_reg   <= 1'b0;
            ldr_done_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cpu_done_reg <= 1'b0;
            ldr_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        owner_reg <= grant_ldr ? OWN_LDR : OWN_CPU;
                        we_reg    <= grant_ldr ? ldr_we : cpu_we;
                        addr_reg  <= grant_ldr ? ldr_addr[AW:1] : cpu_addr[AW:1];
                        wdata_reg <= grant_ldr ? ldr_wdata : cpu_wdata;
                        cnt_reg   <= LAT_INIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        last_owner_reg <= owner_reg;
                        if (owner_reg == OWN_LDR) begin
                            ldr_done_reg <= 1'b1;
                            if (!we_reg) begin
                                ldr_rdata_reg <= mem_rdata;
                            end
                        end else begin
                            cpu_done_reg <= 1'b1;
                            if (!we_reg) begin
                                cpu_rdata_reg <= mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_we    = mem_en & we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign ldr_rdata = ldr_rdata_reg;
    assign cpu_done  = cpu_done_reg;
    assign ldr_done  = ldr_done_reg;
    assign cpu_stall = cpu_req & ~cpu_done_reg;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters:
  - the pipeline MEM stage (cpu port);
  - a loader/debug port (ldr) that preloads or inspects data memory while the CPU runs.
- Sequences each access through a fixed-latency memory model and returns read data with a one-cycle done pulse.
- Holds cpu_stall high so the pipeline freezes until its own access completes.

Parameters:
- AW, 10, word-address width to memory (1024 x 16-bit words)
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7

Ports:
- clock  in  1  pipeline clock; all state updates on the falling edge, matching the pipeline update edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  MEM-stage access request; held until cpu_done
- cpu_we  in  1  1 = store (sw), 0 = load (lw)
- cpu_addr  in  16  byte address (ALU output)
- cpu_wdata  in  16  store data
- cpu_rdata  out  16  load data; valid while cpu_done is high, then held
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  freezes the pipeline
- ldr_req  in  1  loader request; held until ldr_done
- ldr_we  in  1  write enable
- ldr_addr  in  16  byte address
- ldr_wdata  in  16  write data
- ldr_rdata  out  16  read data; valid while ldr_done is high, then held
- ldr_done  out  1  one-cycle completion pulse
- mem_en  out  1  access strobe, exactly one cycle per transaction
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  AW  word address = byte address >> 1, truncated to AW bits
- mem_wdata  out  16  write data
- mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset values: all outputs 0; state IDLE; last_owner = LDR, so the CPU wins the first tie.
- State IDLE:
  - If any req is high, select the winner and register we/addr/wdata from the winner.
  - Drive mem_en=1 and mem_we=we in the next cycle (state ISSUE).
  - Load cnt = MEM_LAT.
- State ISSUE:
  - mem_en is high for this cycle only.
  - Go to WAIT.
- State WAIT:
  - Decrement cnt each cycle.
  - When cnt reaches 0: capture mem_rdata into the owner's rdata (reads only), pulse the owner's done for one cycle, set last_owner, return to IDLE.
- Latency:
  - Request seen in IDLE -> done pulse exactly MEM_LAT+2 cycles later, for reads and writes alike.
  - Back-to-back transactions: the next grant is evaluated in the IDLE cycle that follows done.
- cpu_stall = cpu_req & ~cpu_done (combinational).
  - It stays high while the CPU waits behind a loader transaction.
  - It drops in the done cycle.
- Requester rules:
  - A requester must deassert req or present a new request in the cycle after done.
  - A req still high in IDLE starts a new transaction.
- Req dropped mid-transaction: the transaction completes anyway; done is still pulsed and rdata is updated.
- Address handling:
  - Bit 0 is ignored (odd byte addresses alias to the even word).
  - Upper bits beyond AW+1 are dropped, so addresses wrap.
- The non-owner's rdata holds its previous value.
- Reset mid-transaction aborts it:
  - mem_en is forced low immediately at the next edge.
  - No done pulse; rdata cleared to 0.
  - A write already strobed is not undone.
- Arbitration without the optional feature: fixed priority, CPU wins every tie.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined:
  - 2-way round robin: on a simultaneous request, the requester that is not last_owner wins.
  - A single requester always wins.
- Undefined:
  - Fixed CPU priority.
  - last_owner is still tracked but unused.
  - The loader can starve under continuous CPU traffic; this is acceptable for debug use.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT);
  - the owner encoding (OWN_CPU=0, OWN_LDR=1);
  - the default AW and MEM_LAT constants.
- One sub-module, dmem_arb_pick:
  - combinational winner select from cpu_req, ldr_req and last_owner;
  - contains the DMEM_ARB_RR_EN switch.
- FSM, counter and capture registers stay in dmem_arbiter.

Test Plan:
- CPU read, MEM_LAT=1: mem[2]=16'h0005, cpu_req/we=0/addr=16'h0004 -> mem_en one cycle with mem_addr=2; cpu_done 3 cycles after request; cpu_rdata=16'h0005; cpu_stall high for exactly 3 cycles.
- CPU write then read, MEM_LAT=3: write 16'h0007 to addr 16'h0002, then read addr 16'h0003 -> both done pulses 5 cycles after their requests; read returns 16'h0007 (odd-address alias).
- Simultaneous cpu_req and ldr_req, both held, after reset:
  - Fixed mode: CPU granted for all transactions; ldr_done never pulses while CPU requests continuously.
  - With DMEM_ARB_RR_EN: grants alternate CPU, LDR, CPU.
- Loader read while CPU waits: ldr granted first, cpu_req rises the next cycle -> cpu_stall high through the ldr transaction and its own; cpu_done is 2*(MEM_LAT+2)-1 cycles after cpu_req.
- Reset asserted in WAIT, MEM_LAT=4 -> next edge: state IDLE, no done pulse, rdata=0, mem_en=0; the first tie after release goes to the CPU.
- Address wrap, AW=10: cpu_addr=16'h0802 -> mem_addr=1.
